uart_rx_endpoint: RTL

- Receive-side UART block for the `Tx` serial line driven by the CPU top.
- Deserialises 8N1-style frames (parity configurable) using 16x oversampling.
- Presents each received byte on a valid/ready handshake with per-byte error flags.
- Used on the board side and in simulation benches to observe the core's UART output.

---
 rtl/uart_rx_endpoint.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_endpoint.sv
// 16x-oversampled UART receiver: 2-flop synchroniser, start/data/parity/stop FSM,
// byte presented on a valid/ready handshake with per-byte error flags and sticky overrun.
module uart_rx_endpoint #(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int TICK_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic PAR_ODD = (PARITY_MODE == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic                 meta_q, rx_s_q, rx_prev_q, idle_seen_q;
  logic [1:0]           fill_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic                 tick, fall, start_det;
  state_t               state_q, state_d;
  logic [3:0]           os_cnt_q, os_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 dlv_q, dlv_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 load;

  // fill_q marks when rx_s_q holds a real line sample rather than its reset value,
  // so a line held low through reset is never mistaken for an idle-to-start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      fill_q      <= 2'b00;
      idle_seen_q <= 1'b0;
    end else begin
      meta_q    <= rx;
      rx_s_q    <= meta_q;
      rx_prev_q <= rx_s_q;
      fill_q    <= {fill_q[0], 1'b1};
      if (fill_q[1] && rx_s_q) idle_seen_q <= 1'b1;
    end
  end

  assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign fall      = idle_seen_q && rx_prev_q && !rx_s_q;
  assign start_det = (state_q == S_IDLE) && fall;

  always_comb begin
    tick_cnt_d = tick_cnt_q + TW'(1);
    if (start_det || tick) tick_cnt_d = '0;
  end

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    dlv_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d  = S_START;
          os_cnt_d = 4'd0;
          perr_d   = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          if (os_cnt_q == 4'd7) begin
            os_cnt_d  = 4'd0;
            bit_idx_d = 3'd0;
            state_d   = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (os_cnt_q == 4'd15) begin
            // Right-shift in: after DATA_BITS samples the first-received bit sits at bit 0.
            shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
            os_cnt_d  = 4'd0;
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'(DATA_BITS - 1))
              state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (os_cnt_q == 4'd15) begin
            perr_d   = rx_s_q ^ (^shift_q) ^ PAR_ODD;
            os_cnt_d = 4'd0;
            state_d  = S_STOP;
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (os_cnt_q == 4'd15) begin
            dlv_d    = 1'b1;
            ferr_d   = !rx_s_q;
            os_cnt_d = 4'd0;
            state_d  = rx_s_q ? S_IDLE : S_BREAK;
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Delivery slot: accept into the holding register only if it is free or draining this cycle.
  always_comb begin
    load         = dlv_q && (!rx_valid_q || rx_ready);
    rx_valid_d   = (rx_valid_q && !rx_ready) || load;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    if (load) begin
      rx_data_d    = shift_q;
      parity_err_d = perr_q;
      frame_err_d  = ferr_q;
    end
    overrun_d = overrun_q || (dlv_q && !load);
    if (overrun_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      state_q      <= S_IDLE;
      os_cnt_q     <= 4'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      dlv_q        <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      dlv_q        <= dlv_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule
